traffic_demand_gen: RTL and testbench
=====================================

// Module: traffic_demand_gen
// PURPOSE
//  Vehicle-demand front end for the two-approach traffic light controller. Turns raw loop-detector
//  inputs det_a/det_b into the controller's demand inputs inp_a/inp_b, and reads back the lamp codes
//  l_a/l_b the controller drives (0 green, 1 yellow, 2 red). Adds debounce, gap-out extension and a
//  max-green cap, so a steady stream on one approach cannot starve the other.
// PARAMETERS
//  DEB_CYC      4   consecutive synchronized samples needed to change debounced presence
//  GAP_CYC      8   cycles of green held with no presence before demand drops (gap-out)
//  MAX_GRN_CYC  64  green cycles after which demand is forced off if the other approach is waiting
//  CNT_W        8   width of the gap and green counters; must hold MAX_GRN_CYC
// PORTS
//  clk        in   1  clock
//  reset      in   1  synchronous, active-high reset
//  det_a      in   1  raw detector, approach A (asynchronous)
//  det_b      in   1  raw detector, approach B (asynchronous)
//  l_a        in   2  lamp code, approach A, from the controller
//  l_b        in   2  lamp code, approach B, from the controller
//  inp_a      out  1  demand to controller, approach A (registered)
//  inp_b      out  1  demand to controller, approach B (registered)
//  err_light  out  1  sticky illegal-lamp flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; both FSMs IDLE; sync flops, debounce and counters cleared; pres_x=0.
//  - det_x passes through a 2-flop synchronizer. pres_x toggles only after DEB_CYC consecutive sync
//    samples of the opposite value. Latency from the first edge sampling det_x=1 to inp_x=1 is
//    2+DEB_CYC+1 cycles when the FSM is IDLE.
//  - green_x = (l_x==0). Each approach has its own FSM; inp_x = (state==DEMAND || state==SERVE).
//    IDLE:      pres_x -> DEMAND.
//    DEMAND:    green_x -> SERVE (gap=GAP_CYC, grn=0). !pres_x && !green_x -> IDLE.
//    SERVE:     each cycle grn++ (saturates); gap reloads GAP_CYC while pres_x, else decrements.
//               Exits in priority order:
//               (1) !green_x -> DEMAND if pres_x, else IDLE;
//               (2) gap==0 -> IDLE;
//               (3) grn==MAX_GRN_CYC-1 with the other FSM in DEMAND -> FORCE_OFF.
//    FORCE_OFF: inp_x=0 until !green_x, then -> DEMAND if pres_x, else IDLE.
//  - Gap-out and the max cap firing in the same cycle: gap-out wins (IDLE).
//  - Both FSMs may sit in DEMAND at the same time; the controller arbitrates.
//  - Reset mid-SERVE or mid-FORCE_OFF: next cycle is IDLE with inp_x=0; debounce restarts from 0.
//  - Lamp code 3 on l_x counts as not green for the FSMs.
// CONFIGURATION
//  LIGHT_CHECK_EN defined:
//    - err_light is set the cycle after (l_a!=2 && l_b!=2), or after either code==3.
//    - It stays 1 until reset.
//  LIGHT_CHECK_EN undefined:
//    - err_light is tied to 0 and the checker logic is not built.
// STRUCTURE
//  - Package traffic_pkg holds:
//    - lamp constants LT_GREEN=2'd0, LT_YELLOW=2'd1, LT_RED=2'd2;
//    - the demand-FSM state encoding IDLE/DEMAND/SERVE/FORCE_OFF.
//  - Sub-module traffic_debounce (synchronizer + DEB_CYC filter), instantiated once per approach.
//  - Both demand FSMs and the optional checker are inline.
// TESTING
//  1 det_a=1 held from cycle 0, l_a=2 -> inp_a rises at cycle 7, stays 1; det_a 3-cycle glitch -> no rise.
//  2 inp_a=1, l_a goes 0, det_a drops -> inp_a falls after DEB_CYC+GAP_CYC+3 cycles (FSM -> IDLE).
//  3 det_a constant 1, l_a=0, det_b=1, l_b=2 -> inp_a falls 64 cycles after SERVE entry;
//    inp_a stays 0 until l_a!=0; inp_b=1 throughout.
//  4 As 3 with det_b=0 -> inp_a stays 1 indefinitely (no cap without waiting demand).
//  5 reset pulsed mid-SERVE -> inp_a=inp_b=0 next cycle; re-demand needs the full 7-cycle latency.
//  6 LIGHT_CHECK_EN defined, l_a=0 with l_b=1 for one cycle -> err_light=1 and sticky;
//    undefined -> err_light=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp codes and demand-FSM state encoding for the traffic demand front end.
package traffic_pkg;

    localparam logic [1:0] LT_GREEN  = 2'd0;
    localparam logic [1:0] LT_YELLOW = 2'd1;
    localparam logic [1:0] LT_RED    = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEMAND    = 2'd1,
        SERVE     = 2'd2,
        FORCE_OFF = 2'd3
    } dmd_state_t;

endpackage

// File: rtl/traffic_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample filter on one loop detector.
module traffic_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic det,
    output logic pres
);

    localparam int DW = $clog2(DEB_CYC + 1);

    logic [1:0]    sync;
    logic [DW-1:0] cnt;

    // pres flips on the edge that takes the DEB_CYC-th consecutive opposing sample
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            pres <= 1'b0;
        end else begin
            sync <= {sync[0], det};
            if (sync[1] != pres) begin
                if (cnt == DW'(DEB_CYC - 1)) begin
                    pres <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/traffic_demand_gen.sv
// Demand front end: debounced presence, gap-out and max-green cap per approach.
// Define LIGHT_CHECK_EN to build the sticky illegal-lamp checker on err_light.
module traffic_demand_gen
    import traffic_pkg::*;
#(
    parameter int DEB_CYC     = 4,
    parameter int GAP_CYC     = 8,
    parameter int MAX_GRN_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       det_a,
    input  logic       det_b,
    input  logic [1:0] l_a,
    input  logic [1:0] l_b,
    output logic       inp_a,
    output logic       inp_b,
    output logic       err_light
);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] GRN_TOP  = CNT_W'(MAX_GRN_CYC - 1);

    logic [1:0]       pres;
    logic [1:0]       green;
    logic [1:0]       inp_nx;
    dmd_state_t       state    [2];
    dmd_state_t       state_nx [2];
    logic [CNT_W-1:0] gap      [2];
    logic [CNT_W-1:0] gap_nx   [2];
    logic [CNT_W-1:0] grn      [2];
    logic [CNT_W-1:0] grn_nx   [2];

    traffic_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .det   (det_a),
        .pres  (pres[0])
    );

    traffic_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .det   (det_b),
        .pres  (pres[1])
    );

    assign green[0] = (l_a == LT_GREEN);
    assign green[1] = (l_b == LT_GREEN);

    always_comb begin
        inp_nx = '0;
        for (int i = 0; i < 2; i++) begin
            state_nx[i] = state[i];
            gap_nx[i]   = gap[i];
            grn_nx[i]   = grn[i];
            case (state[i])
                IDLE: begin
                    if (pres[i]) state_nx[i] = DEMAND;
                end
                DEMAND: begin
                    if (green[i]) begin
                        state_nx[i] = SERVE;
                        gap_nx[i]   = GAP_LOAD;
                        grn_nx[i]   = '0;
                    end else if (!pres[i]) begin
                        state_nx[i] = IDLE;
                    end
                end
                SERVE: begin
                    // grn parks at the cap value so a late-arriving waiter still trips it
                    if (grn[i] != GRN_TOP) grn_nx[i] = grn[i] + 1'b1;
                    if (pres[i])            gap_nx[i] = GAP_LOAD;
                    else if (gap[i] != '0)  gap_nx[i] = gap[i] - 1'b1;
                    if (!green[i])
                        state_nx[i] = pres[i] ? DEMAND : IDLE;
                    else if (gap[i] == '0)
                        state_nx[i] = IDLE;
                    else if (grn[i] == GRN_TOP && state[1-i] == DEMAND)
                        state_nx[i] = FORCE_OFF;
                end
                FORCE_OFF: begin
                    if (!green[i]) state_nx[i] = pres[i] ? DEMAND : IDLE;
                end
                default: state_nx[i] = IDLE;
            endcase
            inp_nx[i] = (state_nx[i] == DEMAND) || (state_nx[i] == SERVE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                gap[i]   <= '0;
                grn[i]   <= '0;
            end
            inp_a <= 1'b0;
            inp_b <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nx[i];
                gap[i]   <= gap_nx[i];
                grn[i]   <= grn_nx[i];
            end
            inp_a <= inp_nx[0];
            inp_b <= inp_nx[1];
        end
    end

`ifdef LIGHT_CHECK_EN
    // neither approach red, or an undefined lamp code, latches until reset
    always_ff @(posedge clk) begin
        if (reset)
            err_light <= 1'b0;
        else if ((l_a != LT_RED && l_b != LT_RED) || l_a == 2'd3 || l_b == 2'd3)
            err_light <= 1'b1;
    end
`else
    assign err_light = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_demand_gen.sv
// Directed bench for traffic_demand_gen: latency/debounce vector table plus multi-cycle sequences.
module tb_traffic_demand_gen;
    import traffic_pkg::*;

`ifdef LIGHT_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       det_a, det_b;
    logic [1:0] l_a, l_b;
    logic       inp_a, inp_b, err_light;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_demand_gen dut (
        .clk       (clk),
        .reset     (reset),
        .det_a     (det_a),
        .det_b     (det_b),
        .l_a       (l_a),
        .l_b       (l_b),
        .inp_a     (inp_a),
        .inp_b     (inp_b),
        .err_light (err_light)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pulse_len;
        logic [1:0] lamp;
        int         check_cyc;
        logic       exp_a;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        det_a = 1'b0;
        det_b = 1'b0;
        l_a   = LT_RED;
        l_b   = LT_RED;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int bad;
        vec[0] = '{3,   LT_RED,    10, 1'b0};
        vec[1] = '{1,   LT_RED,    10, 1'b0};
        vec[2] = '{100, LT_RED,    6,  1'b0};
        vec[3] = '{100, LT_RED,    7,  1'b1};
        vec[4] = '{4,   LT_RED,    7,  1'b1};
        vec[5] = '{4,   LT_RED,    10, 1'b1};
        vec[6] = '{4,   LT_RED,    11, 1'b0};
        vec[7] = '{100, LT_YELLOW, 7,  1'b1};
        vec[8] = '{100, LT_GREEN,  8,  1'b1};
        vec[9] = '{100, 2'd3,      8,  1'b1};

        reset = 1'b1;
        det_a = 1'b0;
        det_b = 1'b0;
        l_a   = LT_RED;
        l_b   = LT_RED;
        @(negedge clk);

        // reset state
        do_reset();
        check("reset_inp_a", inp_a, 1'b0);
        check("reset_inp_b", inp_b, 1'b0);
        check("reset_err", err_light, 1'b0);

        // latency / debounce table, det_a high for pulse_len edges
        for (int v = 0; v < NV; v++) begin
            do_reset();
            l_a   = vec[v].lamp;
            det_a = 1'b1;
            for (int c = 1; c <= vec[v].check_cyc; c++) begin
                tick();
                if (c == vec[v].pulse_len) det_a = 1'b0;
            end
            check($sformatf("vec%0d_inp_a", v), inp_a, vec[v].exp_a);
            check($sformatf("vec%0d_inp_b", v), inp_b, 1'b0);
        end

        // gap-out after detector drops while green
        do_reset();
        det_a = 1'b1;
        repeat (7) tick();
        check("gap_pre_inp_a", inp_a, 1'b1);
        l_a   = LT_GREEN;
        det_a = 1'b0;
        repeat (14) tick();
        check("gap_hold_inp_a", inp_a, 1'b1);
        tick();
        check("gap_out_inp_a", inp_a, 1'b0);

        // max-green cap with approach B waiting
        do_reset();
        det_a = 1'b1;
        det_b = 1'b1;
        l_a   = LT_GREEN;
        bad   = 0;
        for (int c = 1; c <= 71; c++) begin
            tick();
            if (c >= 7 && inp_b !== 1'b1) bad++;
        end
        check("cap_before_inp_a", inp_a, 1'b1);
        tick();
        check("cap_fire_inp_a", inp_a, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inp_a !== 1'b0) bad++;
            if (inp_b !== 1'b1) bad++;
        end
        check("cap_hold_bad_cycles", bad, 0);
        l_a = LT_YELLOW;
        tick();
        check("cap_release_inp_a", inp_a, 1'b1);
        check("cap_release_inp_b", inp_b, 1'b1);

        // no cap without a waiting approach
        do_reset();
        det_a = 1'b1;
        l_a   = LT_GREEN;
        bad   = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c >= 8 && inp_a !== 1'b1) bad++;
        end
        check("nocap_bad_cycles", bad, 0);
        check("nocap_inp_b", inp_b, 1'b0);

        // reset pulsed mid-SERVE
        do_reset();
        det_a = 1'b1;
        l_a   = LT_GREEN;
        repeat (20) tick();
        check("midserve_inp_a", inp_a, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_inp_a", inp_a, 1'b0);
        check("rst_inp_b", inp_b, 1'b0);
        reset = 1'b0;
        repeat (6) tick();
        check("rst_relat6_inp_a", inp_a, 1'b0);
        tick();
        check("rst_relat7_inp_a", inp_a, 1'b1);

        // illegal lamp combination: green with yellow for one cycle
        do_reset();
        check("err_after_reset", err_light, 1'b0);
        l_a = LT_GREEN;
        l_b = LT_YELLOW;
        tick();
        l_b = LT_RED;
        check("err_set", err_light, ERR_EXP);
        repeat (5) tick();
        check("err_sticky", err_light, ERR_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
